// File: rtl/cm_pkg.sv
// ----------------------------------------------------------------------------
// cm_pkg
// Shared definitions for the configurable Booth multiplier:
//   - operating mode encodings (cm_i values)
//   - controller state type
//   - Booth iteration counts per operand width
// ----------------------------------------------------------------------------
package cm_pkg;

  localparam logic [1:0] CM_SINGLE8  = 2'b00;
  localparam logic [1:0] CM_DUAL8    = 2'b01;
  localparam logic [1:0] CM_SINGLE16 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ITER8  = 8;
  localparam int ITER16 = 16;

  // Modes 10 and 11 both run the full 16-bit multiply.
  function automatic logic [4:0] iter_count(input logic [1:0] cm);
    return cm[1] ? 5'(ITER16) : 5'(ITER8);
  endfunction

endpackage

// File: rtl/configurable_multiplier_if.sv
// ----------------------------------------------------------------------------
// configurable_multiplier_if
// Control/result bundle of the multiplier.
//   enable_i        start request (sampled by the datapath only when idle)
//   cm_i            mode select
//   multiplicand_i  operand A
//   multiplier_i    operand B
//   product16x16_o  result register
//   data_valid_o    one-cycle completion pulse
// master: the requester (drives operands); slave: the multiplier.
// ----------------------------------------------------------------------------
interface configurable_multiplier_if;

  logic        enable_i;
  logic [1:0]  cm_i;
  logic [15:0] multiplicand_i;
  logic [15:0] multiplier_i;
  logic [31:0] product16x16_o;
  logic        data_valid_o;

  modport master (
    output enable_i, cm_i, multiplicand_i, multiplier_i,
    input  product16x16_o, data_valid_o
  );

  modport slave (
    input  enable_i, cm_i, multiplicand_i, multiplier_i,
    output product16x16_o, data_valid_o
  );

endinterface

// File: rtl/configurable_multiplier_booth_lane.sv
// ----------------------------------------------------------------------------
// booth_lane
// One 8-bit radix-2 Booth step datapath: 9-bit accumulator, 8-bit multiplier
// shift register and the q(-1) bit. Two lanes either work independently
// (8-bit modes) or are chained into one 16-bit Booth engine (chain_i=1).
//
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   load_i           clear acc/q(-1) and load q with b_i
//   step_i           perform one add/sub + arithmetic shift
//   chain_i          1 = lanes chained as a 16-bit engine
//   a_i, b_i         multiplicand byte, multiplier byte (load only)
//   cas_cin_i        carry from the lower lane      (used by UPPER when chained)
//   cas_pair_i       Booth pair of the lower lane   (used by UPPER when chained)
//   cas_acc_i        bit shifted into acc top       (used by lower when chained)
//   cas_q_i          bit shifted into q top         (any lane when chained)
//   cout_o           carry out of acc bit 7
//   sum_lsb_o        bit 0 of the pre-shift sum
//   q_lsb_o, pair_o  q[0] and {q[0], q(-1)}
//   acc_o, q_o       low accumulator byte and q, for result assembly
// ----------------------------------------------------------------------------
module booth_lane #(
  parameter bit UPPER = 1'b0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic       step_i,
  input  logic       chain_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cas_cin_i,
  input  logic [1:0] cas_pair_i,
  input  logic       cas_acc_i,
  input  logic       cas_q_i,
  output logic       cout_o,
  output logic       sum_lsb_o,
  output logic       q_lsb_o,
  output logic [1:0] pair_o,
  output logic [7:0] acc_o,
  output logic [7:0] q_o
);

  logic [8:0] acc_reg;
  logic [7:0] q_reg;
  logic       q_m1_reg;

  logic       use_cas;
  logic       cut_top;
  logic [1:0] pair;
  logic       add_en;
  logic       sub_en;
  logic [8:0] addend;
  logic       cin;
  logic [8:0] low_sum;
  logic [8:0] sum;
  logic [8:0] acc_next;
  logic [7:0] q_next;

  // Chained: the upper lane follows the lower lane's Booth decision and
  // takes its carry; the lower lane's accumulator top bit comes from the
  // upper lane, making one 17-bit accumulator {upper[8:0], lower[7:0]}.
  assign use_cas = chain_i & UPPER;
  assign cut_top = chain_i & ~UPPER;

  assign pair   = use_cas ? cas_pair_i : {q_reg[0], q_m1_reg};
  assign add_en = (pair == 2'b01);
  assign sub_en = (pair == 2'b10);

  // Subtraction is add of the one's complement plus a carry-in of 1.
  assign addend = add_en ? {a_i[7], a_i} :
                  sub_en ? ~{a_i[7], a_i} : 9'd0;
  assign cin    = use_cas ? cas_cin_i : sub_en;

  // Split the add at bit 7 so the carry can be handed to the upper lane.
  assign low_sum = {1'b0, acc_reg[7:0]} + {1'b0, addend[7:0]} + {8'd0, cin};
  assign sum     = {acc_reg[8] ^ addend[8] ^ low_sum[8], low_sum[7:0]};

  assign acc_next = cut_top ? {cas_acc_i, cas_acc_i, sum[7:1]}
                            : {sum[8], sum[8:1]};
  assign q_next   = {chain_i ? cas_q_i : sum[0], q_reg[7:1]};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_reg  <= '0;
      q_reg    <= '0;
      q_m1_reg <= 1'b0;
    end else if (load_i) begin
      acc_reg  <= '0;
      q_reg    <= b_i;
      q_m1_reg <= 1'b0;
    end else if (step_i) begin
      acc_reg  <= acc_next;
      q_reg    <= q_next;
      q_m1_reg <= q_reg[0];
    end
  end

  assign cout_o    = low_sum[8];
  assign sum_lsb_o = sum[0];
  assign q_lsb_o   = q_reg[0];
  assign pair_o    = {q_reg[0], q_m1_reg};
  assign acc_o     = acc_reg[7:0];
  assign q_o       = q_reg;

endmodule

// File: rtl/configurable_multiplier.sv
// ----------------------------------------------------------------------------
// configurable_multiplier
// Iterative signed radix-2 Booth multiplier: one 8x8, two parallel 8x8 lanes,
// or one 16x16, selected per operation by cm_i.
//
// Ports:
//   clk_i    clock (rising edge)
//   reset_i  synchronous active-high reset; aborts any operation
//   bus      configurable_multiplier_if.slave
//            (enable_i, cm_i, multiplicand_i, multiplier_i in;
//             product16x16_o, data_valid_o out)
//
// Timing: start sampled at edge k, N Booth steps (N = 8 or 16), DONE state,
// data_valid_o high for the cycle after edge k+N+1. Issue period N+2.
// ----------------------------------------------------------------------------
module configurable_multiplier
  import cm_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      reset_i,
  configurable_multiplier_if.slave  bus
);

  state_t      state_reg;
  logic [4:0]  cnt_reg;
  logic [15:0] a_reg;
  logic [1:0]  cm_reg;
  logic [31:0] product_reg;
  logic        valid_reg;

  logic        load;
  logic        step;
  logic        chain;
  logic [31:0] result;

  logic       lo_cout, lo_sum_lsb, lo_q_lsb, hi_cout, hi_sum_lsb, hi_q_lsb;
  logic [1:0] lo_pair, hi_pair;
  logic [7:0] lo_acc, lo_q, hi_acc, hi_q;
  logic       unused_cascade;

  assign load  = (state_reg == IDLE) && bus.enable_i;
  assign step  = (state_reg == BUSY);
  assign chain = cm_reg[1];

  // Operands enter the q registers directly at load; A is only needed
  // during the steps, so the latched copy is used.
  booth_lane #(.UPPER(1'b0)) lane_lo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (load),
    .step_i     (step),
    .chain_i    (chain),
    .a_i        (a_reg[7:0]),
    .b_i        (bus.multiplier_i[7:0]),
    .cas_cin_i  (1'b0),
    .cas_pair_i (2'b00),
    .cas_acc_i  (hi_sum_lsb),
    .cas_q_i    (hi_q_lsb),
    .cout_o     (lo_cout),
    .sum_lsb_o  (lo_sum_lsb),
    .q_lsb_o    (lo_q_lsb),
    .pair_o     (lo_pair),
    .acc_o      (lo_acc),
    .q_o        (lo_q)
  );

  booth_lane #(.UPPER(1'b1)) lane_hi (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (load),
    .step_i     (step),
    .chain_i    (chain),
    .a_i        (a_reg[15:8]),
    .b_i        (bus.multiplier_i[15:8]),
    .cas_cin_i  (lo_cout),
    .cas_pair_i (lo_pair),
    .cas_acc_i  (1'b0),
    .cas_q_i    (lo_sum_lsb),
    .cout_o     (hi_cout),
    .sum_lsb_o  (hi_sum_lsb),
    .q_lsb_o    (hi_q_lsb),
    .pair_o     (hi_pair),
    .acc_o      (hi_acc),
    .q_o        (hi_q)
  );

  // Cascade outputs that only matter in the other lane's direction.
  assign unused_cascade = ^{hi_cout, hi_pair, lo_q_lsb};

  always_comb begin
    result = '0;
    case (cm_reg)
      CM_SINGLE8:  result = {{16{lo_acc[7]}}, lo_acc, lo_q};
      CM_DUAL8:    result = {hi_acc, hi_q, lo_acc, lo_q};
      CM_SINGLE16: result = {hi_acc, lo_acc, hi_q, lo_q};
      default:     result = {hi_acc, lo_acc, hi_q, lo_q};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      a_reg       <= '0;
      cm_reg      <= '0;
      product_reg <= '0;
      valid_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.enable_i) begin
            a_reg     <= bus.multiplicand_i;
            cm_reg    <= bus.cm_i;
            cnt_reg   <= iter_count(bus.cm_i);
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg - 5'd1;
          if (cnt_reg == 5'd1) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          product_reg <= result;
          valid_reg   <= 1'b1;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.product16x16_o = product_reg;
  assign bus.data_valid_o   = valid_reg;

endmodule

// File: tb/tb_configurable_multiplier.sv
// ----------------------------------------------------------------------------
// tb_configurable_multiplier
// Scoreboard bench: every started operation pushes its reference product;
// a monitor pops and compares on each data_valid_o pulse.
// ----------------------------------------------------------------------------
module tb_configurable_multiplier;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  configurable_multiplier_if mi ();

  configurable_multiplier dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (mi.slave)
  );

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference product computed from the signed operand interpretation.
  function automatic logic [31:0] model(input logic [1:0] cm, input logic [15:0] a,
                                        input logic [15:0] b);
    logic signed [7:0]  al, ah, bl, bh;
    logic signed [15:0] pl, ph;
    logic signed [31:0] pf;
    al = a[7:0];  ah = a[15:8];
    bl = b[7:0];  bh = b[15:8];
    pl = al * bl;
    ph = ah * bh;
    pf = $signed(a) * $signed(b);
    case (cm)
      2'b00:   return {{16{pl[15]}}, pl};
      2'b01:   return {ph, pl};
      default: return pf;
    endcase
  endfunction

  function automatic int latency(input logic [1:0] cm);
    return (cm[1] ? 16 : 8) + 2;
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && mi.data_valid_o) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", {31'd0, mi.data_valid_o}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("product", mi.product16x16_o, mon_exp);
      end
    end
  end

  task automatic scramble_inputs();
    mi.multiplicand_i = 16'($urandom);
    mi.multiplier_i   = 16'($urandom);
    mi.cm_i           = 2'($urandom);
  endtask

  // Counts negedges until data_valid_o, bounded.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!mi.data_valid_o && cycles < 60);
  endtask

  task automatic run_op(input logic [1:0] cm, input logic [15:0] a, input logic [15:0] b);
    int          cyc;
    logic [31:0] exp;
    exp = model(cm, a, b);
    @(negedge clk);
    mi.enable_i       = 1'b1;
    mi.cm_i           = cm;
    mi.multiplicand_i = a;
    mi.multiplier_i   = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    mi.enable_i = 1'b0;
    scramble_inputs();
    wait_valid(cyc);
    check_eq("latency", 32'(cyc), 32'(latency(cm)));
    $display("[TB] op cm=%b a=%04h b=%04h product=%08h expected=%08h latency=%0d",
             cm, a, b, mi.product16x16_o, exp, cyc);
    @(negedge clk);
    check_eq("pulse_width", {31'd0, mi.data_valid_o}, 32'd0);
    repeat (2) @(negedge clk);
    check_eq("hold", mi.product16x16_o, exp);
  endtask

  int          cyc;
  int          seen;
  logic [31:0] last_exp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    mi.enable_i       = 1'b0;
    mi.cm_i           = 2'b00;
    mi.multiplicand_i = '0;
    mi.multiplier_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_product", mi.product16x16_o, 32'd0);
    check_eq("reset_valid", {31'd0, mi.data_valid_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back 16-bit with enable held high.
    @(negedge clk);
    mi.enable_i = 1'b1; mi.cm_i = 2'b10;
    mi.multiplicand_i = 16'h8080; mi.multiplier_i = 16'h8003;
    exp_q.push_back(model(2'b10, 16'h8080, 16'h8003));
    @(posedge clk); #1;
    wait_valid(cyc);
    check_eq("b2b_latency0", 32'(cyc), 32'd18);
    $display("[TB] b2b#0 product=%08h", mi.product16x16_o);
    exp_q.push_back(model(2'b10, 16'h8080, 16'h8003));
    @(posedge clk); #1;
    mi.enable_i = 1'b0;
    wait_valid(cyc);
    check_eq("b2b_period", 32'(cyc), 32'd18);
    $display("[TB] b2b#1 product=%08h", mi.product16x16_o);

    // Directed cases.
    run_op(2'b10, 16'hF2BA, 16'h1BF7);
    run_op(2'b01, 16'h8080, 16'h8003);
    run_op(2'b00, 16'h8080, 16'h8003);
    run_op(2'b00, 16'h1280, 16'h7703);
    run_op(2'b10, 16'h8000, 16'h8000);
    run_op(2'b11, 16'h8000, 16'h7FFF);
    run_op(2'b01, 16'h7F80, 16'h7F80);
    run_op(2'b01, 16'h80FF, 16'h7F01);
    run_op(2'b00, 16'h007F, 16'h0080);

    // Reset in the middle of BUSY discards the operation.
    @(negedge clk);
    mi.enable_i = 1'b1; mi.cm_i = 2'b10;
    mi.multiplicand_i = 16'h1234; mi.multiplier_i = 16'h5678;
    @(posedge clk); #1;
    mi.enable_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midreset_product", mi.product16x16_o, 32'd0);
    check_eq("midreset_valid", {31'd0, mi.data_valid_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (mi.data_valid_o) seen++;
    end
    check_eq("no_pulse_after_reset", 32'(seen), 32'd0);
    $display("[TB] mid-op reset: product=%08h pulses=%0d", mi.product16x16_o, seen);
    run_op(2'b10, 16'h1234, 16'h5678);

    // Random operations across all modes.
    for (int i = 0; i < 10; i++) begin
      run_op(2'($urandom), 16'($urandom), 16'($urandom));
    end
    last_exp = mi.product16x16_o === 32'bx ? 32'd0 : mi.product16x16_o;

    // Idle with enable low: no pulses, result held.
    last_exp = model(2'b01, 16'h5AA5, 16'hC33C);
    run_op(2'b01, 16'h5AA5, 16'hC33C);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (mi.data_valid_o) seen++;
    end
    check_eq("idle_no_valid", 32'(seen), 32'd0);
    check_eq("idle_hold", mi.product16x16_o, last_exp);

    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
